// File: rtl/pipe_regs_fde_if.sv
// pipe_regs_fde_if
// Bundles the signals between the Fetch/Decode/Execute pipeline-register
// bank and its neighbours: the hazard-unit controls, the fetch-side and
// decode-side inputs, the IF/ID and ID/EX register contents, and the
// performance counters.
//   master : hazard unit / fetch / decode side (drives controls and stage inputs)
//   slave  : pipe_regs_fde (drives PCF, IF/ID, ID/EX contents and counters)
interface pipe_regs_fde_if #(
    parameter int XLEN = 32
);
    // hazard-unit controls
    logic            StallF, StallD, FlushD, FlushE;
    // fetch side
    logic [XLEN-1:0] PCNextF, PCF, PCPlus4F;
    logic [31:0]     InstrF;
    // IF/ID contents
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD, PCPlus4D;
    logic            ValidD;
    // decode-side inputs
    logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
    logic [4:0]      Rs1D, Rs2D, RdD;
    // ID/EX contents
    logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            ValidE;
    // performance counters
    logic [31:0]     StallCycles, FlushCycles;

    modport master (
        output StallF, StallD, FlushD, FlushE,
        output PCNextF, InstrF, PCPlus4F,
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
        output RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
        input  StallCycles, FlushCycles
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE,
        input  PCNextF, InstrF, PCPlus4F,
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
        input  RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
        output PCF, InstrD, PCD, PCPlus4D, ValidD,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
        output StallCycles, FlushCycles
    );
endinterface

// File: rtl/pipe_regs_fde.sv
// pipe_regs_fde
// PC register, IF/ID register and ID/EX register of the 5-stage RV32I core.
// Bubbles are architecturally inert: NOP in IF/ID, all-zero controls and
// register fields in ID/EX, valid bits cleared.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipe_regs_fde_if.slave (controls in, stage contents and counters out)
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/flush cycle
// counters; without it StallCycles/FlushCycles are tied to zero.
module pipe_regs_fde #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    pipe_regs_fde_if.slave bus
);

    always_ff @(posedge clk) begin
        if (reset)            bus.PCF <= RESET_PC;
        else if (!bus.StallF) bus.PCF <= bus.PCNextF;
    end

    // flush outranks stall so a wrong-path instruction is never kept
    always_ff @(posedge clk) begin
        if (reset || bus.FlushD) begin
            bus.InstrD   <= NOP_INSTR;
            bus.PCD      <= '0;
            bus.PCPlus4D <= '0;
            bus.ValidD   <= 1'b0;
        end else if (!bus.StallD) begin
            bus.InstrD   <= bus.InstrF;
            bus.PCD      <= bus.PCF;
            bus.PCPlus4D <= bus.PCPlus4F;
            bus.ValidD   <= 1'b1;
        end
    end

    // ID/EX never needs to hold, so it only loads or bubbles
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.ALUControlE <= 3'b000;
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ImmExtE     <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.ValidE      <= 1'b0;
        end else begin
            bus.RegWriteE   <= bus.RegWriteD;
            bus.MemWriteE   <= bus.MemWriteD;
            bus.JumpE       <= bus.JumpD;
            bus.BranchE     <= bus.BranchD;
            bus.ALUSrcE     <= bus.ALUSrcD;
            bus.ResultSrcE  <= bus.ResultSrcD;
            bus.ALUControlE <= bus.ALUControlD;
            bus.RD1E        <= bus.RD1D;
            bus.RD2E        <= bus.RD2D;
            bus.ImmExtE     <= bus.ImmExtD;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.Rs1E        <= bus.Rs1D;
            bus.Rs2E        <= bus.Rs2D;
            bus.RdE         <= bus.RdD;
            bus.ValidE      <= bus.ValidD;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    // a stall overridden by a flush is not a real stall cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (bus.StallD && !bus.FlushD && stallCnt != 32'hFFFF_FFFF)
                stallCnt <= stallCnt + 32'd1;
            if (bus.FlushE && flushCnt != 32'hFFFF_FFFF)
                flushCnt <= flushCnt + 32'd1;
        end
    end

    assign bus.StallCycles = stallCnt;
    assign bus.FlushCycles = flushCnt;
`else
    assign bus.StallCycles = '0;
    assign bus.FlushCycles = '0;
`endif

endmodule

// File: doc/pipe_regs_fde.md
# pipe_regs_fde

Pipeline-register bank for the Fetch, Decode and Execute boundaries of the 5-stage RV32I core. It holds the PC register, the IF/ID register and the ID/EX register. It obeys the StallF, StallD, FlushD and FlushE controls driven by the hazard unit, and is the receiving end of that control interface. Bubbles it inserts are architecturally inert: no register write, no memory write, no branch or jump, and source fields reading x0.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, instruction word loaded by IF/ID flush/reset (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- StallF, StallD  in  1  hold PC / hold IF/ID
- FlushD, FlushE  in  1  bubble IF/ID / bubble ID/EX
- PCNextF  in  XLEN  next PC from PC mux
- PCF  out  XLEN  current fetch PC
- InstrF, PCPlus4F  in  32/XLEN  fetch outputs
- InstrD, PCD, PCPlus4D, ValidD  out  32/XLEN/XLEN/1  IF/ID contents
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls
- ResultSrcD  in  2, ALUControlD  in  3
- RD1D, RD2D, ImmExtD  in  XLEN; Rs1D, Rs2D, RdD  in  5
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE  out  (widths as D-side)  ID/EX contents
- StallCycles, FlushCycles  out  32  performance counters (see Configuration)

## Operation
- PC register: reset → RESET_PC; else StallF → hold; else load PCNextF.
- IF/ID, priority reset > FlushD > StallD > load:
  - Reset/flush: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Stall: hold all fields, including ValidD.
  - Load: InstrF, PCF, PCPlus4F; ValidD=1.
- ID/EX, priority reset > FlushE > load. There is no stall input; a hold is never required at this stage.
  - Reset/flush: every control field 0 (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE=2'b00, ALUControlE=3'b000). All data fields 0, Rs1E=Rs2E=RdE=0, ValidE=0.
  - Load: copy all D-side inputs; ValidE=ValidD.
- FlushD and StallD asserted together: flush wins. A wrong-path instruction must not be preserved.
- StallF with FlushD: PC holds and IF/ID bubbles. Each register obeys only its own controls.
- All outputs are direct register outputs. There is no combinational input→output path.

## Timing
- Each stage has a latency of 1 cycle. A value presented at edge N appears on the outputs after edge N.
- Reset values, visible after the first edge with reset=1:
  - PCF=RESET_PC; InstrD=NOP_INSTR.
  - ValidD=ValidE=0.
  - All other outputs 0, including counters.
- Reset asserted mid-stall or mid-flush: reset dominates and everything returns to reset values on that edge.
- Load-use sequence: a one-cycle StallF/StallD/FlushE produces exactly one held F/D cycle and one bubble in E.
- Taken branch: one-cycle FlushD+FlushE kills the two younger instructions. PCF takes the target on the same edge.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - StallCycles increments on every non-reset edge with StallD=1 and FlushD=0.
  - FlushCycles increments on every non-reset edge with FlushE=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- PIPE_PERF_CNT_EN undefined: the counter logic is absent and StallCycles/FlushCycles are tied to 0.

## Test plan
- Reset: hold reset 2 cycles with RESET_PC=32'h100 → PCF=32'h100, InstrD=32'h0000_0013, ValidD=ValidE=0, RegWriteE=0, counters 0.
- Free flow: PCNextF=PCF+4, no controls, InstrF=32'h0030_0093 at PCF=0x100 → next edge InstrD=32'h0030_0093, PCD=0x100, ValidD=1; following edge ValidE=1, PCE=0x100.
- Load-use stall: one cycle StallF=StallD=FlushE=1 → PCF and InstrD unchanged for that edge, ValidE=0, RegWriteE=0, RdE=0; next cycle the D instruction advances normally.
- Branch flush: FlushD=FlushE=1 with PCNextF=0x200 → PCF=0x200, InstrD=NOP_INSTR, ValidD=0, ValidE=0, MemWriteE=0, BranchE=0.
- Simultaneous FlushD+StallD+StallF: PCF holds, InstrD=NOP_INSTR, ValidD=0. With PIPE_PERF_CNT_EN, StallCycles does not increment.
- Counters (PIPE_PERF_CNT_EN): 5 stall cycles and 3 flush cycles → StallCycles=5, FlushCycles=3. Preload a counter via force to 32'hFFFF_FFFF plus one event → remains 32'hFFFF_FFFF. Reset mid-run → both 0.
